// File: rtl/ctrl_input_pkg.sv
// Shared widths, switch modes and button indices for the controller input front end.
package ctrl_input_pkg;

  localparam int BTN_SZ = 3;
  localparam int SW_SZ  = 2;

  localparam int BTN_RST = 0;
  localparam int BTN_ADD = 1;
  localparam int BTN_SUB = 2;

  localparam int CLK_HZ_DEF    = 125_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;

  typedef enum logic [SW_SZ-1:0] {
    SW_NORMAL = 2'b00,
    SW_ADJ_GR = 2'b01,
    SW_ADJ_RD = 2'b10
  } sw_mode_e;

  // Only add/minus may auto-repeat; reset-to-default must fire once per press.
  localparam logic [BTN_SZ-1:0] REPEAT_MASK =
    BTN_SZ'((1 << BTN_ADD) | (1 << BTN_SUB)) & ~BTN_SZ'(1 << BTN_RST);

  function automatic logic [BTN_SZ-1:0] lowest_bit(input logic [BTN_SZ-1:0] req);
    return req & (~req + 1'b1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-stable-cycle debouncer.
// rise_o pulses in the first cycle the debounced level reads high.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic lvl_o,
  output logic rise_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync   <= '0;
      cnt    <= '0;
      lvl_o  <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      sync   <= {sync[0], in_i};
      rise_o <= 1'b0;
      if (sync[1] == lvl_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        lvl_o  <= ~lvl_o;
        rise_o <= ~lvl_o;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_input_gen.sv
// Count-down tick divider plus debounced, arbitrated button events and switch levels.
// Define CTRL_INPUT_AUTO_REPEAT_EN to auto-repeat the add/minus buttons while held.
module ctrl_input_gen
  import ctrl_input_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEF,
  parameter int TICK_HZ      = 1,
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int REPEAT_DELAY = 60_000_000,
  parameter int REPEAT_RATE  = 40_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BTN_SZ-1:0] btn_raw_i,
  input  logic [SW_SZ-1:0]  sw_raw_i,
  output logic              time_o,
  output logic [BTN_SZ-1:0] btn_o,
  output logic [SW_SZ-1:0]  sw_o
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);
  // An illegal parameter set keeps the tick silent rather than producing a bogus rate.
  localparam bit CFG_OK = (TICK_DIV >= 2) && (DB_CYCLES >= 1) &&
                          (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);

  logic [TW-1:0]     tick_cnt;
  logic [BTN_SZ-1:0] btn_lvl;
  logic [BTN_SZ-1:0] btn_rise;
  logic [BTN_SZ-1:0] rep_req;
  logic [BTN_SZ-1:0] btn_req;
  logic [SW_SZ-1:0]  sw_lvl;
  logic [SW_SZ-1:0]  sw_rise;
  logic              unused_sw_rise;

  assign unused_sw_rise = &{1'b0, sw_rise};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tick_cnt <= '0;
      time_o   <= 1'b0;
    end else begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      time_o   <= CFG_OK && (tick_cnt == TICK_PRE);
    end
  end

  for (genvar i = 0; i < BTN_SZ; i++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .in_i   (btn_raw_i[i]),
      .lvl_o  (btn_lvl[i]),
      .rise_o (btn_rise[i])
    );
  end

  for (genvar i = 0; i < SW_SZ; i++) begin : g_sw
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .in_i   (sw_raw_i[i]),
      .lvl_o  (sw_lvl[i]),
      .rise_o (sw_rise[i])
    );
  end

`ifdef CTRL_INPUT_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);

  for (genvar i = 0; i < BTN_SZ; i++) begin : g_rep
    if (REPEAT_MASK[i]) begin : g_on
      logic [RW-1:0] rep_cnt;
      // Down-counter parked at the initial delay while released; reload with the rate on terminal count.
      always_ff @(posedge clk_i) begin
        if (!rst_i || !btn_lvl[i] || btn_rise[i]) begin
          rep_cnt <= RW'(REPEAT_DELAY - 1);
        end else if (rep_cnt == '0) begin
          rep_cnt <= RW'(REPEAT_RATE - 1);
        end else begin
          rep_cnt <= rep_cnt - 1'b1;
        end
      end
      assign rep_req[i] = btn_lvl[i] && !btn_rise[i] && (rep_cnt == '0);
    end else begin : g_off
      assign rep_req[i] = 1'b0;
    end
  end
`else
  logic unused_btn_lvl;
  assign unused_btn_lvl = &{1'b0, btn_lvl};
  assign rep_req = '0;
`endif

  assign btn_req = btn_rise | (rep_req & REPEAT_MASK);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      btn_o <= '0;
      sw_o  <= SW_NORMAL;
    end else begin
      btn_o <= lowest_bit(btn_req);
      sw_o  <= sw_lvl;
    end
  end

endmodule

// File: doc/ctrl_input_gen.md
# ctrl_input_gen

Input-side front end for the traffic-light controller. It produces the controller's `time_i` count-down tick and conditions the raw board buttons and switches into clean, synchronous, single-cycle events. It sits between the board pins and the controller. The controller consumes `time_o`, `btn_o` and `sw_o` directly and needs no further debounce.

## Interface
- `CLK_HZ`, 125_000_000: system clock frequency.
- `TICK_HZ`, 1: count-down tick rate. `TICK_DIV = CLK_HZ/TICK_HZ`, which must be ≥ 2.
- `DB_CYCLES`, 1_000_000: consecutive stable cycles required to accept a button or switch level change. Must be ≥ 1.
- `REPEAT_DELAY`, 60_000_000: hold time before the first auto-repeat (used only with `AUTO_REPEAT_EN`).
- `REPEAT_RATE`, 40_000_000: auto-repeat period. Must exceed the controller's 0x1ffffff-cycle lockout.
- `clk_i` in 1: system clock; all logic on the rising edge.
- `rst_i` in 1: synchronous reset, active-low.
- `btn_raw_i` in `` `BTN_SZ ``: asynchronous push buttons, active-high.
- `sw_raw_i` in `` `SW_SZ ``: asynchronous mode switches.
- `time_o` out 1: one-cycle count-down tick.
- `btn_o` out `` `BTN_SZ ``: one-cycle press events, at most one bit high per cycle.
- `sw_o` out `` `SW_SZ ``: synchronized, debounced switch value.

## Operation
- **Reset** (`rst_i`=0 at a clock edge):
  - tick counter clears to 0;
  - all synchronizers, debounce counters and debounced levels clear to 0;
  - `time_o`=0, `btn_o`=0, `sw_o`=0 (= `` `NORMAL ``).
  - Reset mid-operation abandons any partial debounce or repeat, and no pulse is emitted for it.
- **Tick divider:**
  - Counter runs 0 .. `TICK_DIV`-1 and wraps.
  - `time_o`=1 exactly in the cycle the counter equals `TICK_DIV`-1.
  - The divider is free-running and ignores buttons and switches.
- **Synchronizer:** each raw bit passes through a 2-flop synchronizer.
- **Debounce** (per bit, `btn_debounce` instance):
  - Holds a debounced level `lvl` and a counter `cnt`.
  - If synced input == `lvl`: `cnt` := 0.
  - Else: `cnt` increments. When `cnt` reaches `DB_CYCLES`-1, `lvl` flips and `cnt` := 0.
  - Glitches shorter than `DB_CYCLES` cycles never change `lvl`.
- **Switches:** `sw_o` = debounced levels of all `` `SW_SZ `` bits, updated independently per bit.
- **Buttons:**
  - A 0→1 transition of a button's `lvl` raises a request for that button.
  - A 1→0 transition produces nothing.
- **Arbitration:**
  - If several requests occur in the same cycle, the lowest index wins and is emitted.
  - The others are dropped, not deferred.
  - This guarantees `btn_o` is one-hot or zero.
- `time_o` and `btn_o` may be high in the same cycle; they are independent.

## Timing
- All outputs are registered.
- Raw button held high from cycle t (stable) → `btn_o` bit high in cycle t+`DB_CYCLES`+3, for exactly 1 cycle.
- Raw release: no output. A new press requires the release to be accepted first (`DB_CYCLES` stable low).
- `sw_o` changes at t+`DB_CYCLES`+3 after a stable raw change at t.
- The first `time_o` occurs in cycle `TICK_DIV`-1 after the first cycle with `rst_i`=1. After that, exactly one pulse every `TICK_DIV` cycles.

## Configuration
- Macro: `CTRL_INPUT_AUTO_REPEAT_EN`.
- **Defined:**
  - While `btn[1]` or `btn[2]` (add/minus) stays debounced-high, extra pulses are emitted.
  - The first extra pulse comes `REPEAT_DELAY` cycles after the initial pulse, then one every `REPEAT_RATE` cycles.
  - Releasing the button cancels repeating immediately.
  - `btn[0]` (reset-to-default) never repeats.
  - Repeat pulses pass through the same arbitration as new presses.
- **Undefined:** one pulse per accepted press only. The repeat counters and parameters are unused and must synthesize away.

## Structure
- `` `BTN_SZ ``, `` `SW_SZ `` and `` `NORMAL `` come from `def.v`.
- Add to `def.v`: `` `CLK_HZ `` and `` `DB_CYCLES `` defaults, and the button index constants `` `BTN_RST ``=0, `` `BTN_ADD ``=1, `` `BTN_SUB ``=2.
- Sub-module `btn_debounce` (parameter `DB_CYCLES`; ports `clk_i`, `rst_i`, `in_i`, `lvl_o`, `rise_o`):
  - includes the 2-flop synchronizer;
  - instantiated once per button bit and once per switch bit.

## Test plan
- Parameters for all scenarios: `CLK_HZ`=20, `TICK_HZ`=1, `DB_CYCLES`=4, `REPEAT_DELAY`=30, `REPEAT_RATE`=10.
- **Reset then run 100 cycles** → `time_o` pulses at cycles 19, 39, 59, 79, 99 only. All other outputs stay 0.
- **Raise `btn_raw_i[1]` at cycle 10 and hold for 20 cycles** → `btn_o`=3'b010 in cycle 17 only. No event on release.
- **Pulse `btn_raw_i[2]` high for 3 cycles, repeated 5 times with 1-cycle gaps** → `btn_o` stays 0.
- **Raise `btn_raw_i[0]` and `btn_raw_i[2]` in the same cycle** → a single `btn_o`=3'b001. Bit 2 is never pulsed for that press.
- **Change `sw_raw_i` to `` `ADJ_GR ``, stable** → `sw_o` updates 7 cycles later. Apply `rst_i`=0 at cycle 5 of a pending switch change → `sw_o` stays `` `NORMAL ``.
- **With `CTRL_INPUT_AUTO_REPEAT_EN`, hold `btn_raw_i[1]` for 70 cycles from cycle 0** → pulses at cycles 7, 37, 47, 57, 67. Holding `btn_raw_i[0]` the same way gives a pulse at cycle 7 only.
